// File: rtl/relay_pkg.sv
// Shared constants and types for the relay line receive framer.
package relay_pkg;

   localparam logic [2:0] HUNT = 3'd0;
   localparam logic [2:0] SYNC = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] PAR  = 3'd3;
   localparam logic [2:0] STOP = 3'd4;

   localparam int SYNC_BITS = 4;
   localparam int DATA_BITS = 8;

   localparam logic [3:0] SYNC_DEFAULT = 4'hA;

   typedef struct packed {
      logic frame_err;
      logic parity_err;
      logic overflow;
   } rx_err_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/relay_link_rx_if.sv
// Byte handshake from the relay framer to the SSP serializer.
interface relay_link_rx_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );

endinterface

// File: rtl/relay_byte_fifo.sv
// Show-ahead byte FIFO with flush; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module relay_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic [7:0]              push_data,
   input  logic                    pop,
   output logic [7:0]              pop_data,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty    = level == '0;
   assign full     = level == (AW+1)'(DEPTH);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         unique case (1'b1)
            push_ok && !pop_ok: level <= level + (AW+1)'(1);
            pop_ok && !push_ok: level <= level - (AW+1)'(1);
            default:            level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/relay_link_rx.sv
// Relay line receive framer: sync hunt, byte capture, parity/stop
// check, and buffering toward the SSP serializer.
module relay_link_rx
   import relay_pkg::*;
#(
   parameter int         BIT_CLKS     = 8,
   parameter logic [3:0] SYNC_PATTERN = SYNC_DEFAULT,
   parameter int         FIFO_DEPTH   = 4
) (
   input  logic                         ck_1356meg,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         data_in,
   relay_link_rx_if.master              rx,
   output logic                         busy,
   output logic                         frame_err,
   output logic                         parity_err,
   output logic                         overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

   localparam int            PW  = $clog2(BIT_CLKS);
   localparam logic [PW-1:0] MID = PW'(BIT_CLKS/2 - 1);

   logic          meta;
   logic          line;
   logic          line_q;
   logic          rise;
   logic          toggle;
   logic          strobe;
   logic [PW-1:0] phase;
   logic [2:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [3:0]    sync_word;
   logic          push;
   logic          full;
   logic          empty;
   logic          pop_ok;
   rx_err_t       err;

   assign rise      = line & ~line_q;
   assign toggle    = line ^ line_q;
   assign strobe    = phase == MID;
   assign busy      = state != HUNT;
   assign sync_word = {shreg[2:0], line};
   assign push      = enable && state == STOP && strobe && !line;
   assign pop_ok    = rx.rx_ready && !empty;
   assign rx.rx_valid = !empty;

   assign frame_err  = err.frame_err;
   assign parity_err = err.parity_err;
   assign overflow   = err.overflow;

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         meta   <= 1'b0;
         line   <= 1'b0;
         line_q <= 1'b0;
      end else begin
         meta   <= data_in;
         line   <= meta;
         line_q <= line;
      end
   end

   // Re-centre on every line transition so the strobe tracks the peer.
   always_ff @(posedge ck_1356meg) begin
      if (rst)
         phase <= '0;
      else if ((busy && toggle) || (!busy && rise))
         phase <= '0;
      else
         phase <= phase + PW'(1);
   end

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         state   <= HUNT;
         bit_cnt <= '0;
         shreg   <= '0;
         err     <= '0;
      end else if (!enable) begin
         state   <= HUNT;
         bit_cnt <= '0;
         err     <= '0;
      end else begin
         err          <= '0;
         err.overflow <= push && full && !pop_ok;
         case (state)
            HUNT: begin
               if (rise) begin
                  state   <= SYNC;
                  bit_cnt <= '0;
               end
            end
            SYNC: begin
               if (strobe) begin
                  shreg   <= {shreg[6:0], line};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'(SYNC_BITS-1)) begin
                     bit_cnt <= '0;
                     if (sync_word == SYNC_PATTERN) begin
                        state <= DATA;
                     end else begin
                        state         <= HUNT;
                        err.frame_err <= 1'b1;
                     end
                  end
               end
            end
            DATA: begin
               if (strobe) begin
                  shreg   <= {shreg[6:0], line};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'(DATA_BITS-1)) begin
                     bit_cnt <= '0;
                     state   <= PAR;
                  end
               end
            end
            PAR: begin
               if (strobe) begin
                  if (line != even_parity(shreg)) begin
                     state          <= HUNT;
                     err.parity_err <= 1'b1;
                  end else begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (strobe) begin
                  state <= HUNT;
                  if (line)
                     err.frame_err <= 1'b1;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   relay_byte_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (ck_1356meg),
      .rst       (rst),
      .flush     (!enable),
      .push      (push),
      .push_data (shreg),
      .pop       (rx.rx_ready),
      .pop_data  (rx.rx_data),
      .empty     (empty),
      .full      (full),
      .level     (fifo_level)
   );

endmodule

// File: tb/tb_relay_link_rx.sv
// Randomized bench for relay_link_rx against a queue-based frame model.
module tb_relay_link_rx;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       data_in;
   logic       busy;
   logic       frame_err;
   logic       parity_err;
   logic       overflow;
   logic [2:0] fifo_level;

   logic rand_mode = 1'b0;
   logic rnd_ready = 1'b0;
   logic dir_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_fe = 0, n_pe = 0, n_ov = 0;
   int exp_fe = 0, exp_pe = 0, exp_ov = 0;
   bit fe_q = 0, pe_q = 0, ov_q = 0;

   logic [7:0] q[$];

   relay_link_rx_if rif ();

   assign rif.rx_ready = rand_mode ? rnd_ready : dir_ready;

   relay_link_rx #(
      .BIT_CLKS     (8),
      .SYNC_PATTERN (4'hA),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .ck_1356meg (clk),
      .rst        (rst),
      .enable     (enable),
      .data_in    (data_in),
      .rx         (rif),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_frame_err"}, n_fe, exp_fe);
      chk({tag, "_parity_err"}, n_pe, exp_pe);
      chk({tag, "_overflow"}, n_ov, exp_ov);
   endtask

   // Outcome of one complete frame, decided at its stop-sample cycle.
   task automatic model_frame(input logic [7:0] b, input logic par,
                              input logic stop);
      bit pop_now;
      if (par != ^b) begin
         exp_pe++;
      end else if (stop) begin
         exp_fe++;
      end else begin
         pop_now = rif.rx_ready && q.size() > 0;
         if (q.size() < DEPTH || pop_now)
            q.push_back(b);
         else
            exp_ov++;
      end
   endtask

   task automatic drive_bits(input logic [15:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--) begin
         data_in = bits[k];
         tick(8);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par,
                             input logic stop, input bit lat,
                             input bit pop_push);
      logic [13:0] bits;
      bits = {4'hA, b, par, stop};
      for (int k = 13; k >= 1; k--) begin
         data_in = bits[k];
         tick(8);
      end
      data_in = stop;
      repeat (6) @(posedge clk);
      #1;
      if (pop_push)
         dir_ready = 1'b1;
      #2;
      model_frame(b, par, stop);
      if (lat) begin
         chk("lat_valid_before", rif.rx_valid, 0);
         chk("lat_busy_stop", busy, 1);
      end
      @(posedge clk);
      #1;
      if (pop_push)
         dir_ready = 1'b0;
      if (lat) begin
         chk("lat_valid_rise", rif.rx_valid, 1);
         chk("lat_data", rif.rx_data, b);
         chk("lat_busy_done", busy, 0);
      end
      @(posedge clk);
      #1;
      data_in = 1'b0;
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, ^b, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rnd_ready = ($urandom_range(0, 2) == 0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (rif.rx_valid && rif.rx_ready) begin
            if (q.size() == 0)
               chk("pop_without_byte", q.size(), 1);
            else
               chk("rx_data", rif.rx_data, q.pop_front());
         end
         if (frame_err || parity_err || overflow)
            chk("err_onehot", $countones({frame_err, parity_err, overflow}), 1);
         if (frame_err) begin
            n_fe++;
            chk("frame_err_width", fe_q, 0);
         end
         if (parity_err) begin
            n_pe++;
            chk("parity_err_width", pe_q, 0);
         end
         if (overflow) begin
            n_ov++;
            chk("overflow_width", ov_q, 0);
         end
      end
      fe_q = frame_err;
      pe_q = parity_err;
      ov_q = overflow;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic       par;
      logic       stop;
      int         r;

      rst       = 1'b1;
      enable    = 1'b1;
      data_in   = 1'b0;
      dir_ready = 1'b0;
      tick(3);
      chk("rst_valid", rif.rx_valid, 0);
      chk("rst_data", rif.rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_parity_err", parity_err, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_level", fifo_level, 0);
      rst = 1'b0;
      tick(4);

      // single ideal frame with latency check
      dir_ready = 1'b1;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(4);
      chk_counts("t1");

      // three back-to-back frames held, then drained
      dir_ready = 1'b0;
      good(8'h5A);
      good(8'hC3);
      good(8'h07);
      tick(2);
      chk("t2_level3", fifo_level, 3);
      dir_ready = 1'b1;
      tick(3);
      chk("t2_valid_after", rif.rx_valid, 0);
      chk("t2_level0", fifo_level, 0);
      chk("t2_model_empty", q.size(), 0);

      // wrong sync nibble, then a good frame
      tick(20);
      drive_bits(16'h0005, 3);
      data_in = 1'b1;
      tick(7);
      chk("t3_fe_pulse", frame_err, 1);
      exp_fe++;
      tick(1);
      chk("t3_fe_clear", frame_err, 0);
      chk("t3_busy", busy, 0);
      data_in = 1'b0;
      tick(100);
      good(8'h3C);
      tick(4);
      chk("t3_level", fifo_level, 0);
      chk("t3_model_empty", q.size(), 0);
      chk_counts("t3");

      // bad parity, bad stop
      dir_ready = 1'b0;
      send_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(4);
      chk("t4_par_level", fifo_level, 0);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(4);
      chk("t4_stop_level", fifo_level, 0);
      chk_counts("t4");

      // overflow on fifth frame
      good(8'h11);
      good(8'h22);
      good(8'h33);
      good(8'h44);
      good(8'h55);
      tick(4);
      chk("t5_level_full", fifo_level, 4);
      chk_counts("t5a");
      dir_ready = 1'b1;
      tick(6);
      dir_ready = 1'b0;
      chk("t5_drained", fifo_level, 0);

      // fifth push coincides with a pop: no overflow
      good(8'h61);
      good(8'h62);
      good(8'h63);
      good(8'h64);
      send_frame(8'h65, ^8'h65, 1'b0, 1'b0, 1'b1);
      tick(2);
      chk("t5_level_pop", fifo_level, 4);
      chk("t5_head", rif.rx_data, 8'h62);
      chk_counts("t5b");
      dir_ready = 1'b1;
      tick(6);
      dir_ready = 1'b0;
      chk("t5_model_empty", q.size(), 0);

      // enable dropped mid-frame
      good(8'h11);
      tick(2);
      chk("t6_level_pre", fifo_level, 1);
      drive_bits(16'h00AA, 8);
      chk("t6_busy_mid", busy, 1);
      data_in = 1'b0;
      enable  = 1'b0;
      tick(1);
      chk("t6_busy_off", busy, 0);
      chk("t6_level_flush", fifo_level, 0);
      q.delete();
      tick(20);
      enable = 1'b1;
      tick(5);
      good(8'hA5);
      tick(2);
      chk("t6_level_after", fifo_level, 1);
      chk("t6_data", rif.rx_data, 8'hA5);
      dir_ready = 1'b1;
      tick(3);
      dir_ready = 1'b0;
      chk_counts("t6");

      // reset pulsed mid-frame
      good(8'h3C);
      tick(2);
      drive_bits(16'h00AA, 8);
      chk("t7_busy_mid", busy, 1);
      data_in = 1'b0;
      rst     = 1'b1;
      tick(1);
      chk("t7_busy_off", busy, 0);
      chk("t7_level_flush", fifo_level, 0);
      chk("t7_data_zero", rif.rx_data, 0);
      q.delete();
      rst = 1'b0;
      tick(20);
      dir_ready = 1'b1;
      good(8'hA5);
      tick(4);
      chk("t7_model_empty", q.size(), 0);
      chk_counts("t7");

      // randomized frames with random consumer back-pressure
      rand_mode = 1'b1;
      for (int i = 0; i < 24; i++) begin
         b    = 8'($urandom);
         r    = $urandom_range(0, 9);
         par  = ^b;
         stop = 1'b0;
         if (r < 2)
            par = ~par;
         else if (r < 4)
            stop = 1'b1;
         send_frame(b, par, stop, 1'b0, 1'b0);
         tick($urandom_range(3, 12));
      end
      rand_mode = 1'b0;
      dir_ready = 1'b1;
      tick(10);
      chk("rand_level", fifo_level, 0);
      chk("rand_model_empty", q.size(), 0);
      chk_counts("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/relay_link_rx.md
Name: relay_link_rx

Overview:
- Receive framer for the inter-Proxmark relay line.
- Oversamples the serial `data_in` stream from the peer Proxmark and hunts for the sync nibble. It then captures one data byte, checks even parity and the stop bit, and buffers good bytes.
- Buffered bytes go through a small FIFO with a valid/ready handshake to the downstream SSP serializer, which clocks them out to the ARM.
- Sits between the relay pin and the SSP-to-ARM shifter in relay/slave mode.

Parameters:
- BIT_CLKS, 8, clocks per line bit (8 gives 1.695 Mbit/s at 13.56 MHz); power of 2, minimum 4.
- SYNC_PATTERN, 4'hA, sync nibble, sent MSB first.
- FIFO_DEPTH, 4, byte buffer entries; power of 2, minimum 2.

Ports:
- ck_1356meg  in  1  13.56 MHz clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when 0, receiver is held in HUNT and the FIFO is flushed.
- data_in  in  1  asynchronous serial line from peer Proxmark; idle low.
- rx_data  out  8  head-of-FIFO byte.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts `rx_data` when `rx_valid` and `rx_ready` are both 1 on a clock edge.
- busy  out  1  1 while a frame is in progress (any state except HUNT).
- frame_err  out  1  1-cycle pulse: sync mismatch or bad stop bit.
- parity_err  out  1  1-cycle pulse: parity mismatch.
- overflow  out  1  1-cycle pulse: good byte dropped because FIFO was full.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, `rx_data` = 8'h00, state HUNT, FIFO empty, phase counter 0.
- Input path: 2-flop synchronizer on `data_in`, then an edge detector on the synchronized value. Only the synchronized value is used downstream.
- Phase counter: width log2(BIT_CLKS), free-running mod BIT_CLKS.
  - Cleared to 0 on any synchronized transition while `busy`, and on a rising edge while in HUNT.
  - Sample strobe fires when phase == BIT_CLKS/2-1.
- Frame format on the line: 4 sync bits (SYNC_PATTERN, MSB first), 8 data bits MSB first, 1 even-parity bit (XOR of the data bits), 1 stop bit = 0. Total 14 bits.
- States:
  - HUNT: wait for a synchronized rising edge, then go to SYNC (phase = 0, bit count = 0).
  - SYNC: shift in 4 samples. After the 4th, compare against SYNC_PATTERN. Match goes to DATA; mismatch pulses `frame_err` and returns to HUNT.
  - DATA: shift in 8 samples, then go to PAR.
  - PAR: sample the parity bit. Mismatch pulses `parity_err` and returns to HUNT (byte discarded); otherwise go to STOP.
  - STOP: sample the stop bit. If it is 1, pulse `frame_err` and drop the byte. If it is 0, push the byte to the FIFO, or pulse `overflow` if the FIFO is full. Return to HUNT in all cases.
- Latency: let E be the cycle the first rising edge is detected. With ideal timing, samples land at E+3+8k; the stop sample is at E+107. `rx_valid` rises at E+108 if the FIFO was empty.
- FIFO:
  - Show-ahead: `rx_data` is valid in the same cycle `rx_valid` is 1.
  - Push and pop in the same cycle: level unchanged, order preserved.
  - A push into a full FIFO on the same cycle as a pop is accepted, with no overflow.
  - Pop when empty is ignored.
  - Pointers wrap mod FIFO_DEPTH.
  - `rx_data` holds its value while `rx_valid` is 1 and `rx_ready` is 0.
- `enable` deasserted mid-frame: on the next edge, state goes to HUNT, the partial byte is discarded, the FIFO is flushed, and no error pulse is generated.
- `rst` mid-operation has the same effect as `enable` deasserted, and additionally restores every register to its reset value.
- Error pulses are mutually exclusive and never exceed 1 cycle.

Decomposition:
- Shared package `relay_pkg`:
  - State encoding constants HUNT, SYNC, DATA, PAR, STOP (3 bits, in the same style as the MASTER/SLAVE/DELAY mode defines).
  - Frame length constants: SYNC_BITS=4, DATA_BITS=8.
  - Default SYNC_PATTERN.
- One sub-module, `relay_byte_fifo`: synchronous show-ahead FIFO with push/pop/level/flush. The framer instantiates it.

Test Plan:
- Ideal frame for 0x5A (line bits 1010_01011010_0_0), `rx_ready`=1 → `rx_valid` rises at E+108 with `rx_data`=8'h5A, no error pulses, `busy` low after the stop sample.
- Three back-to-back frames 0x5A, 0xC3, 0x07 (parity bits 0, 0, 1) with `rx_ready`=0 → `fifo_level`=3. Then raise `rx_ready` → bytes read out 5A, C3, 07 on consecutive cycles, then `rx_valid`=0.
- Wrong sync nibble 1011 → `frame_err` pulse at the 4th sample, no FIFO write, next good frame 0x3C is received correctly.
- 0x07 sent with parity bit 0 → single `parity_err` pulse and `fifo_level` stays 0. 0x5A sent with stop bit 1 → single `frame_err` pulse and `fifo_level` stays 0.
- With `rx_ready`=0, send 5 good frames with FIFO_DEPTH=4 → `fifo_level`=4, one `overflow` pulse on the 5th. Repeat with a single pop landing on the 5th push cycle → no overflow, level stays 4.
- Deassert `enable` (or pulse `rst`) during DATA of frame 0xA5 → `busy`=0 and `fifo_level`=0 the next cycle, no error pulse. A subsequent frame 0xA5 (parity 0) is received correctly.
